mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single-port synchronous memory (13-bit word address, 32-bit data, 4-bit byte mask, 1-cycle read latency) between the instruction-fetch requester and the exec_unit load/store requester. Each accepted request becomes one memory access and one acknowledge pulse. The block sits between the core (fetch logic, exec_unit) and the memory on `memaddr`/`membus`. It resolves simultaneous requests by round-robin.

## Interface
Parameters:
- `AW`, 13: word address width.
- `DW`, 32: data width; byte mask width is `DW/8`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `f_req`  in  1  fetch request; held high until `f_ack`.
- `f_addr`  in  AW  fetch word address; stable while `f_req`.
- `f_ack`  out  1  one-cycle acknowledge; `f_rdata` valid this cycle.
- `f_rdata`  out  DW  fetch read data.
- `d_req`  in  1  data request; held high until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load; stable while `d_req`.
- `d_addr`  in  AW  data word address.
- `d_wdata`  in  DW  store data.
- `d_bmask`  in  DW/8  store byte enables; bit i enables byte i.
- `d_ack`  out  1  one-cycle acknowledge; for loads `d_rdata` is valid this cycle.
- `d_rdata`  out  DW  load data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory word address.
- `mem_wdata`  out  DW  memory write data.
- `mem_bmask`  out  DW/8  memory byte write mask.
- `mem_rdata`  in  DW  memory read data; valid the cycle after `mem_en`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states are IDLE, ACCESS and RESP, with a `last` register (0 = fetch, 1 = data) recording the most recent grant.
- **IDLE:** if neither request is high, stay in IDLE. If exactly one is high, grant it. If both are high, grant the requester not equal to `last`. On a grant:
  - register `mem_en=1`, `mem_addr`, `mem_we` (= `d_we` for data, 0 for fetch), `mem_wdata`, `mem_bmask` (= `d_bmask` for a data store, else 0);
  - record the grantee in `sel`; update `last`;
  - go to ACCESS.
- **ACCESS:** memory performs the access. All `mem_*` strobes and data are registered to 0 for the next cycle. Go to RESP.
- **RESP:** assert `f_ack` or `d_ack` per `sel`. The granted `*_rdata` = `mem_rdata` (combinational pass-through). The non-granted `*_rdata` = 0. Always go to IDLE.
- Outside RESP, both acks are 0 and both rdata outputs are 0.
- Requests are sampled only in IDLE. A requester still holding `req` during its RESP cycle is not re-granted: the FSM passes through IDLE first, and by then the requester must have dropped `req` or presented a new transaction.
- A store with `d_bmask=0` still performs the access cycle, writes no bytes, and is acked.
- For loads and fetches, `mem_bmask` is 0 and `mem_we` is 0.
- Request inputs are ignored while `busy`. A change of address or data during a transaction has no effect on that transaction.

## Timing
- Reset, synchronous, while `rst_n`=0 at the clock edge:
  - state ← IDLE, `last` ← 0 (fetch), so the first conflict grants data;
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_bmask` ← 0;
  - `f_ack`, `d_ack`, `f_rdata`, `d_rdata` ← 0; `busy` ← 0.
- Latency is fixed. If a request is seen in IDLE at cycle N:
  - `mem_en` is high in cycle N+1;
  - the ack is high in cycle N+2;
  - the earliest next grant is sampled in cycle N+3.
- Throughput is one access per 3 cycles.
- With both requesters continuously re-requesting, grants alternate strictly D, F, D, F…
- Reset mid-operation:
  - reset in ACCESS: the memory access presented in that cycle completes at the memory, but no ack is issued, and the requester must reissue;
  - reset in RESP: the ack for that cycle is still driven (combinational from state) and is cleared next cycle.
- `mem_rdata` is never registered internally. The memory must hold its output through the RESP cycle (standard BRAM read-latency 1 behaviour).

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `f_req`=`d_req`=1 → all outputs 0, `busy`=0. After release, the first grant is data: `mem_addr`=`d_addr` in the cycle after the first IDLE.
- Single fetch: `f_addr`=0x0004, memory model returns 0xDEADBEEF → `mem_en`=1/`mem_we`=0/`mem_addr`=0x0004 at N+1; `f_ack`=1, `f_rdata`=0xDEADBEEF at N+2; `d_ack`=0 throughout.
- Store then load: store `d_addr`=0x1FFF, `d_wdata`=0x11223344, `d_bmask`=4'b0101 to a word preset to 0xAABBCCDD → `mem_bmask`=4'b0101, `d_ack` at N+2. A subsequent load of 0x1FFF returns 0xAA22CC44.
- Contention: hold both requests for 4 transactions → grant order D, F, D, F; `f_ack`/`d_ack` pulses spaced 3 cycles apart; never both high together.
- Zero-mask store: `d_we`=1, `d_bmask`=0 → access occurs with `mem_we`=1, `mem_bmask`=0; memory contents unchanged; `d_ack` pulses once.
- Mid-op reset: assert `rst_n`=0 during the ACCESS cycle of a fetch → no `f_ack` follows; state is IDLE, `last`=0. Reissuing the fetch completes normally 3 cycles after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory
// between instruction fetch and the load/store unit.
module mem_arbiter #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [AW-1:0]     f_addr,
  output logic              f_ack,
  output logic [DW-1:0]     f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  input  logic [DW/8-1:0]   d_bmask,
  output logic              d_ack,
  output logic [DW-1:0]     d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_bmask,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] bmask;
  } mem_cmd_t;

  state_t   state_q, state_d;
  logic     last_q, last_d;
  logic     sel_q, sel_d;
  mem_cmd_t cmd_q, cmd_d;
  logic     grant_d, grant_f;
  logic     resp;

  // Data wins a tie unless it was the previous grantee.
  always_comb begin
    grant_d = d_req & (~f_req | ~last_q);
    grant_f = f_req & ~grant_d;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cmd_d   = '0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            state_d     = ACCESS;
            last_d      = 1'b1;
            sel_d       = 1'b1;
            cmd_d.en    = 1'b1;
            cmd_d.we    = d_we;
            cmd_d.addr  = d_addr;
            cmd_d.wdata = d_we ? d_wdata : '0;
            cmd_d.bmask = d_we ? d_bmask : '0;
          end
          grant_f: begin
            state_d    = ACCESS;
            last_d     = 1'b0;
            sel_d      = 1'b0;
            cmd_d.en   = 1'b1;
            cmd_d.addr = f_addr;
          end
          default: ;
        endcase
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cmd_q   <= cmd_d;
    end
  end

  assign mem_en    = cmd_q.en;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_bmask = cmd_q.bmask;

  // Read data is passed straight through; the memory holds it in RESP.
  assign resp    = (state_q == RESP);
  assign f_ack   = resp & ~sel_q;
  assign d_ack   = resp & sel_q;
  assign f_rdata = f_ack ? mem_rdata : '0;
  assign d_rdata = d_ack ? mem_rdata : '0;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected acks
// and a byte-masked memory model behind the arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [12:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [12:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_bmask;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_d;
    bit          cmp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] golden [0:8191];
  logic [31:0] ram [0:8191];
  bit          wr [0:8191];

  mem_arbiter #(.AW(13), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr),
    .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_bmask(d_bmask),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bmask(mem_bmask), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(logic [12:0] a);
    if (a == 13'h0004) return 32'hDEADBEEF;
    if (a == 13'h1FFF) return 32'hAABBCCDD;
    return {3'b101, a, 16'h3C5A};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] nw,
                                        logic [3:0]  bm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (bm[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory model: read latency 1, output held while idle.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= merge(wr[mem_addr] ? ram[mem_addr]
                               : init_val(mem_addr), mem_wdata, mem_bmask);
        wr[mem_addr]  <= 1'b1;
      end
      mem_rdata <= wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (f_ack === 1'b1 || d_ack === 1'b1) begin
      exp_t e;
      chk("ack_exclusive", 32'(f_ack & d_ack), 32'd0);
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected_ack observed=f%0b/d%0b expected=none",
               f_ack, d_ack);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_grantee", 32'(d_ack), 32'(e.is_d));
        if (e.cmp)
          chk("sb_rdata", e.is_d ? d_rdata : f_rdata, e.data);
        chk("sb_other_rdata", e.is_d ? f_rdata : d_rdata, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(bit is_d, bit cmp, logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.cmp  = cmp;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic single(bit is_d, bit we, logic [12:0] addr,
                        logic [31:0] wdata, logic [3:0] bm, string tag);
    bit st;
    st = is_d && we;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr;
      d_wdata = wdata; d_bmask = bm;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    if (st) begin
      push(1'b1, 1'b0, 32'd0);
      golden[addr] = merge(golden[addr], wdata, bm);
    end else begin
      push(is_d, 1'b1, golden[addr]);
    end
    cyc();
    chk({tag, ".mem_en"}, 32'(mem_en), 32'd1);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(st));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, ".mem_bmask"}, 32'(mem_bmask), st ? 32'(bm) : 32'd0);
    if (st) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
    cyc();
    chk({tag, ".ack"}, 32'(is_d ? d_ack : f_ack), 32'd1);
    chk({tag, ".mem_en_off"}, 32'(mem_en), 32'd0);
    f_req = 1'b0;
    d_req = 1'b0;
    cyc();
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".rdata_off"}, f_rdata | d_rdata, 32'd0);
  endtask

  task automatic contend(int n, bit first_d, logic [12:0] da,
                         logic [12:0] fa, string tag);
    bit isd;
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    f_req = 1'b1; f_addr = fa;
    for (int i = 0; i < n; i++) begin
      isd = first_d ^ i[0];
      push(isd, 1'b1, golden[isd ? da : fa]);
    end
    for (int i = 0; i < n; i++) begin
      isd = first_d ^ i[0];
      cyc();
      chk({tag, ".mem_en"}, 32'(mem_en), 32'd1);
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(isd ? da : fa));
      cyc();
      chk({tag, ".d_ack"}, 32'(d_ack), 32'(isd));
      chk({tag, ".f_ack"}, 32'(f_ack), 32'(!isd));
      if (i == n - 1) begin
        d_req = 1'b0;
        f_req = 1'b0;
      end
      cyc();
      chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) golden[i] = init_val(13'(i));
    rst_n = 1'b0;
    f_req = 1'b1; f_addr = 13'h0456;
    d_req = 1'b1; d_we = 1'b0; d_addr = 13'h0123;
    d_wdata = 32'd0; d_bmask = 4'd0;

    cyc();
    cyc();
    chk("rst.mem_en", 32'(mem_en), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.mem_bmask", 32'(mem_bmask), 32'd0);
    chk("rst.acks", 32'({f_ack, d_ack}), 32'd0);
    chk("rst.rdata", f_rdata | d_rdata, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    contend(1, 1'b1, 13'h0123, 13'h0456, "rst_first");

    single(1'b0, 1'b0, 13'h0004, 32'd0, 4'd0, "fetch");

    single(1'b1, 1'b1, 13'h1FFF, 32'h11223344, 4'b0101, "store");
    single(1'b1, 1'b0, 13'h1FFF, 32'd0, 4'd0, "load");

    single(1'b0, 1'b0, 13'h0008, 32'd0, 4'd0, "fetch2");
    contend(4, 1'b1, 13'h0010, 13'h0020, "rr");

    single(1'b1, 1'b1, 13'h0030, 32'hFFFFFFFF, 4'b0000, "zstore");
    single(1'b1, 1'b0, 13'h0030, 32'd0, 4'd0, "zload");

    f_req = 1'b1; f_addr = 13'h0100;
    cyc();
    chk("mid.mem_en", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    cyc();
    chk("mid.f_ack", 32'(f_ack), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.mem_en", 32'(mem_en), 32'd0);
    rst_n = 1'b1;
    contend(2, 1'b1, 13'h0200, 13'h0100, "reissue");

    cyc();
    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
